fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_write_arbiter_if.sv | 52 +++++
 rtl/rr_arbiter2.sv | 24 ++
 rtl/fb_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the frame-buffer write arbiter.
//   FB_H_PIXELS / FB_V_PIXELS : panel geometry (1 bit per pixel)
//   FB_WORDS                  : 16-bit words needed to hold one frame
//   FB_WORD_BITS              : width of one frame-buffer word
//   fb_state_e                : arbiter FSM states
//   fill_word()               : expands the clear polarity bit to a full word
package fb_pkg;

  localparam int unsigned FB_H_PIXELS  = 800;
  localparam int unsigned FB_V_PIXELS  = 480;
  localparam int unsigned FB_WORD_BITS = 16;
  localparam int unsigned FB_WORDS     = (FB_H_PIXELS * FB_V_PIXELS) / FB_WORD_BITS;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // Replicate the clear polarity across a whole word (0 -> 16'h0000, 1 -> 16'hFFFF).
  function automatic logic [FB_WORD_BITS-1:0] fill_word(input logic i_value);
    return {FB_WORD_BITS{i_value}};
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: bundles every non-clock signal of the arbiter.
//   clear_req / clear_value          : full-buffer fill request and polarity
//   req0_* / req1_*                  : two valid/ready word-write requesters
//   write_address / data_in / load   : registered frame-buffer write port
//   clear_busy / clear_done          : sweep status
//   addr_err                         : out-of-range request indication
// Modport slave is the arbiter's view, master is the requesters'/buffer's view.
interface fb_write_arbiter_if
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);

  logic                    clear_req;
  logic                    clear_value;

  logic                    req0_valid;
  logic [ADDR_W-1:0]       req0_addr;
  logic [FB_WORD_BITS-1:0] req0_data;
  logic                    req0_ready;

  logic                    req1_valid;
  logic [ADDR_W-1:0]       req1_addr;
  logic [FB_WORD_BITS-1:0] req1_data;
  logic                    req1_ready;

  logic [ADDR_W-1:0]       write_address;
  logic [FB_WORD_BITS-1:0] data_in;
  logic                    load;
  logic                    clear_busy;
  logic                    clear_done;
  logic                    addr_err;

  modport slave (
    input  clear_req, clear_value,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output write_address, data_in, load,
    output clear_busy, clear_done, addr_err
  );

  modport master (
    output clear_req, clear_value,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  write_address, data_in, load,
    input  clear_busy, clear_done, addr_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, purely combinational.
//   i_valid0 / i_valid1 : request lines
//   i_ptr               : preferred requester when both request
//   o_grant[1:0]        : one-hot grant (all zero when nobody requests)
module rr_arbiter2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    o_grant = 2'b00;
    if (i_ptr == 1'b0) begin
      o_grant[0] = i_valid0;
      o_grant[1] = i_valid1 & ~i_valid0;
    end else begin
      o_grant[1] = i_valid1;
      o_grant[0] = i_valid0 & ~i_valid1;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: merges two word-write requesters onto one registered
// frame-buffer write port and can sweep the whole buffer with a fill value.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : fb_write_arbiter_if.slave (requests, write port, clear status)
// Parameters: FB_WORDS (buffer depth in words), ADDR_W (word-address width).
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FB_WORDS = 24000,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fb_write_arbiter_if.slave    bus
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);

  fb_state_e               r_state;
  logic                    r_ptr;
  logic [ADDR_W-1:0]       r_cnt;
  logic                    r_fill;
  logic                    r_load;
  logic [ADDR_W-1:0]       r_addr;
  logic [FB_WORD_BITS-1:0] r_data;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_addr_err;

  logic [1:0]              w_grant;
  logic                    w_ready0;
  logic                    w_ready1;
  logic                    w_xfer;
  logic                    w_oor;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [FB_WORD_BITS-1:0] w_sel_data;

  rr_arbiter2 u_rr (
    .i_valid0 (bus.req0_valid),
    .i_valid1 (bus.req1_valid),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant)
  );

  // Grants only reach the requesters while idle, out of reset, and with no
  // clear being requested this cycle (clear wins over same-cycle requests).
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (rst_n && (r_state == ST_IDLE) && !bus.clear_req) begin
      w_ready0 = w_grant[0];
      w_ready1 = w_grant[1];
    end else begin
      w_ready0 = 1'b0;
      w_ready1 = 1'b0;
    end
  end

  // Steer the granted requester's address/data and flag out-of-range words.
  always_comb begin
    w_sel_addr = bus.req0_addr;
    w_sel_data = bus.req0_data;
    if (w_ready1) begin
      w_sel_addr = bus.req1_addr;
      w_sel_data = bus.req1_data;
    end else begin
      w_sel_addr = bus.req0_addr;
      w_sel_data = bus.req0_data;
    end
    w_xfer = w_ready0 | w_ready1;
    w_oor  = (w_sel_addr > LP_LAST);
  end

  // Arbiter/sweep FSM with all write-port and status outputs registered.
  // During the sweep r_cnt always equals the address currently on the port,
  // so the terminal compare fires in the cycle that shows the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_cnt      <= '0;
      r_fill     <= 1'b0;
      r_load     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.clear_req) begin
            r_state    <= ST_CLEAR;
            r_fill     <= bus.clear_value;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= fill_word(bus.clear_value);
            r_load     <= 1'b1;
            r_busy     <= 1'b1;
            r_addr_err <= 1'b0;
          end else begin
            r_busy     <= 1'b0;
            r_load     <= w_xfer & ~w_oor;
            r_addr_err <= w_xfer & w_oor;
            if (w_xfer) begin
              // Prefer the requester that was not just served.
              r_ptr <= w_ready0;
              if (!w_oor) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
              end else begin
                r_addr <= r_addr;
                r_data <= r_data;
              end
            end else begin
              r_ptr <= r_ptr;
            end
          end
        end
        ST_CLEAR: begin
          r_addr_err <= 1'b0;
          if (r_cnt == LP_LAST) begin
            r_state <= ST_IDLE;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + LP_ONE;
            r_addr <= r_cnt + LP_ONE;
            r_data <= fill_word(r_fill);
            r_load <= 1'b1;
            r_busy <= 1'b1;
            r_done <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_load     <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_addr_err <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready    = w_ready0;
  assign bus.req1_ready    = w_ready1;
  assign bus.write_address = r_addr;
  assign bus.data_in       = r_data;
  assign bus.load          = r_load;
  assign bus.clear_busy    = r_busy;
  assign bus.clear_done    = r_done;
  assign bus.addr_err      = r_addr_err;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed vectors, a behavioural model checked
// on every falling edge, and literal expectations for the key scenarios.
module tb_fb_write_arbiter;

  localparam int TB_WORDS = 24000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  fb_write_arbiter_if #(.ADDR_W(16)) bus ();

  fb_write_arbiter #(.FB_WORDS(TB_WORDS), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  logic        m_clearing = 1'b0;
  int          m_next     = 0;
  logic [15:0] m_fill     = 16'h0000;
  logic        m_ptr      = 1'b0;
  logic        e_load = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [15:0] e_addr = 16'h0000, e_data = 16'h0000;
  logic        exp_r0, exp_r1;

  // Who may be granted this cycle, from the round-robin rules.
  always_comb begin
    exp_r0 = 1'b0;
    exp_r1 = 1'b0;
    if (rst_n && !m_clearing && !bus.clear_req) begin
      exp_r0 = bus.req0_valid && (!bus.req1_valid || !m_ptr);
      exp_r1 = bus.req1_valid && (!bus.req0_valid ||  m_ptr);
    end
  end

  // What the write port must show after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clearing <= 1'b0; m_next <= 0; m_fill <= 16'h0000; m_ptr <= 1'b0;
      e_load <= 1'b0; e_addr <= 16'h0000; e_data <= 16'h0000;
      e_busy <= 1'b0; e_done <= 1'b0; e_err <= 1'b0;
    end else if (m_clearing) begin
      e_err <= 1'b0;
      if (m_next < TB_WORDS) begin
        e_load <= 1'b1; e_addr <= m_next[15:0]; e_data <= m_fill;
        e_busy <= 1'b1; e_done <= 1'b0; m_next <= m_next + 1;
      end else begin
        m_clearing <= 1'b0; e_load <= 1'b0; e_busy <= 1'b0; e_done <= 1'b1;
      end
    end else begin
      e_busy <= 1'b0; e_done <= 1'b0;
      if (bus.clear_req) begin
        m_clearing <= 1'b1;
        m_fill     <= bus.clear_value ? 16'hFFFF : 16'h0000;
        e_data     <= bus.clear_value ? 16'hFFFF : 16'h0000;
        e_load <= 1'b1; e_addr <= 16'h0000; e_busy <= 1'b1; e_err <= 1'b0;
        m_next <= 1;
      end else if (exp_r0 || exp_r1) begin
        m_ptr <= exp_r0;
        if (int'(exp_r0 ? bus.req0_addr : bus.req1_addr) < TB_WORDS) begin
          e_load <= 1'b1; e_err <= 1'b0;
          e_addr <= exp_r0 ? bus.req0_addr : bus.req1_addr;
          e_data <= exp_r0 ? bus.req0_data : bus.req1_data;
        end else begin
          e_load <= 1'b0; e_err <= 1'b1;
        end
      end else begin
        e_load <= 1'b0; e_err <= 1'b0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("ready0", bus.req0_ready, exp_r0);
    chk("ready1", bus.req1_ready, exp_r1);
    chk("load", bus.load, e_load);
    chk("write_address", bus.write_address, e_addr);
    chk("data_in", bus.data_in, e_data);
    chk("clear_busy", bus.clear_busy, e_busy);
    chk("clear_done", bus.clear_done, e_done);
    chk("addr_err", bus.addr_err, e_err);
  end

  // ---------------- sweep monitor ----------------
  logic mon_en    = 1'b0;
  int   mon_loads = 0;
  int   mon_busy  = 0;
  int   mon_seq   = 0;
  int   mon_bad   = 0;

  // Count loads/busy cycles and verify the sweep address/data sequence.
  always @(negedge clk) begin
    if (mon_en && bus.load) begin
      mon_loads <= mon_loads + 1;
      if (bus.clear_busy) begin
        if (bus.write_address !== mon_seq[15:0] || bus.data_in !== 16'hFFFF)
          mon_bad <= mon_bad + 1;
        mon_seq <= mon_seq + 1;
      end
    end
    if (mon_en && bus.clear_busy) mon_busy <= mon_busy + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  logic [15:0] lit_addr [4];
  logic [15:0] lit_data [4];

  initial begin
    int  cyc;
    bit  seen;
    int  early;
    bit  found;

    bus.clear_req = 1'b0; bus.clear_value = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = 16'd0; bus.req0_data = 16'h0000;
    bus.req1_valid = 1'b0; bus.req1_addr = 16'd0; bus.req1_data = 16'h0000;
    lit_addr[0] = 16'd10; lit_addr[1] = 16'd20; lit_addr[2] = 16'd11; lit_addr[3] = 16'd21;
    lit_data[0] = 16'hA000; lit_data[1] = 16'hB000; lit_data[2] = 16'hA001; lit_data[3] = 16'hB001;

    // Reset state, readies held low even with a valid request.
    #1 rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #3;
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_load", bus.load, 1'b0);
    chk("rst_addr", bus.write_address, 16'd0);
    chk("rst_data", bus.data_in, 16'h0000);
    chk("rst_busy", bus.clear_busy, 1'b0);
    bus.req0_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single requester 0.
    bus.req0_valid = 1'b1; bus.req0_addr = 16'd5; bus.req0_data = 16'hA5A5;
    #1 chk("single_ready0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    chk("single_load", bus.load, 1'b1);
    chk("single_addr", bus.write_address, 16'd5);
    chk("single_data", bus.data_in, 16'hA5A5);
    step();
    chk("single_load_off", bus.load, 1'b0);
    chk("single_hold_addr", bus.write_address, 16'd5);

    // Single requester 1 (returns the pointer to requester 0).
    bus.req1_valid = 1'b1; bus.req1_addr = 16'd7; bus.req1_data = 16'h1234;
    #1 chk("single1_ready1", bus.req1_ready, 1'b1);
    step();
    bus.req1_valid = 1'b0;
    chk("single1_addr", bus.write_address, 16'd7);
    chk("single1_data", bus.data_in, 16'h1234);
    step();

    // Contention: grants alternate 0,1,0,1.
    bus.req0_valid = 1'b1; bus.req0_addr = 16'd10; bus.req0_data = 16'hA000;
    bus.req1_valid = 1'b1; bus.req1_addr = 16'd20; bus.req1_data = 16'hB000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", bus.req0_ready, (k % 2) == 0);
      chk("rr_ready1", bus.req1_ready, (k % 2) == 1);
      step();
      if ((k % 2) == 0) begin
        bus.req0_addr = bus.req0_addr + 16'd1; bus.req0_data = bus.req0_data + 16'd1;
      end else begin
        bus.req1_addr = bus.req1_addr + 16'd1; bus.req1_data = bus.req1_data + 16'd1;
      end
      if (k == 3) begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      end
      chk("rr_load", bus.load, 1'b1);
      chk("rr_addr", bus.write_address, lit_addr[k]);
      chk("rr_data", bus.data_in, lit_data[k]);
    end
    step();
    chk("rr_load_off", bus.load, 1'b0);

    // Out-of-range address is consumed without a write.
    bus.req0_valid = 1'b1; bus.req0_addr = 16'd24000; bus.req0_data = 16'hDEAD;
    #1 chk("oor_ready0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    chk("oor_load", bus.load, 1'b0);
    chk("oor_err", bus.addr_err, 1'b1);
    chk("oor_hold_addr", bus.write_address, 16'd21);
    step();
    chk("oor_err_off", bus.addr_err, 1'b0);

    // Full clear with 1s, requester 1 waiting, a stray clear_req mid-sweep.
    mon_loads = 0; mon_busy = 0; mon_seq = 0; mon_bad = 0; mon_en = 1'b1;
    bus.clear_value = 1'b1; bus.clear_req = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_addr = 16'd30; bus.req1_data = 16'hC0DE;
    #1;
    chk("clr_prio_ready0", bus.req0_ready, 1'b0);
    chk("clr_prio_ready1", bus.req1_ready, 1'b0);
    cyc = 0; seen = 1'b0; early = 0;
    step();
    cyc++;
    bus.clear_req = 1'b0; bus.clear_value = 1'b0;
    while (cyc < 30000 && !seen) begin
      #1;
      if (bus.clear_done) seen = 1'b1;
      else if (bus.req1_ready) early++;
      if (!seen) begin
        step();
        cyc++;
        bus.clear_req = (cyc == 50);
      end
    end
    mon_en = 1'b0;
    chk("clr_done_seen", seen, 1'b1);
    chk("clr_ready1_early", early, 0);
    chk("clr_ready1_at_done", bus.req1_ready, 1'b1);
    chk("clr_loads", mon_loads, TB_WORDS);
    chk("clr_busy_cycles", mon_busy, TB_WORDS);
    chk("clr_seq_errors", mon_bad, 0);
    step();
    bus.req1_valid = 1'b0;
    chk("clr_done_pulse", bus.clear_done, 1'b0);
    chk("post_clr_load", bus.load, 1'b1);
    chk("post_clr_addr", bus.write_address, 16'd30);
    chk("post_clr_data", bus.data_in, 16'hC0DE);
    step();

    // Reset in the middle of a sweep.
    bus.clear_value = 1'b0; bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      #1;
      if (bus.clear_busy && bus.write_address == 16'd100) found = 1'b1;
      else step();
    end
    chk("mid_found", found, 1'b1);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    chk("mid_rst_load", bus.load, 1'b0);
    chk("mid_rst_addr", bus.write_address, 16'd0);
    chk("mid_rst_data", bus.data_in, 16'h0000);
    chk("mid_rst_busy", bus.clear_busy, 1'b0);
    chk("mid_rst_done", bus.clear_done, 1'b0);
    chk("mid_rst_err", bus.addr_err, 1'b0);
    chk("mid_rst_ready0", bus.req0_ready, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    bus.req0_valid = 1'b0;
    mon_loads = 0; mon_busy = 0; mon_seq = 0; mon_bad = 0; mon_en = 1'b1;
    repeat (200) step();
    mon_en = 1'b0;
    chk("post_rst_loads", mon_loads, 0);
    chk("post_rst_busy", mon_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
